bka_sub_16_seq: RTL and testbench
=================================

// Module: bka_sub_16_seq
// PURPOSE
//  Digit-serial 16-bit subtractor: q = a - b (mod 2^16), computed as a + ~b + 1.
//  Processes one DIGIT-bit slice per cycle with a Brent-Kung prefix slice and a registered carry.
//  Sits beside the combinational adders as the area-lean subtract path, behind a valid/ready handshake.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of DIGIT
//  DIGIT  4   bits per cycle; NDIG = WIDTH/DIGIT compute cycles
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a/b valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      q valid; held until taken
//  out_ready  in   1      consumer accepts q
//  q          out  WIDTH  a - b, modulo 2^WIDTH
//  borrow     out  1      present only with BKA_SUB_BORROW_EN: 1 when a < b (unsigned)
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, out_valid=0, q=0, borrow=0, carry=0, digit count=0.
//  FSM states: IDLE, CALC, DONE.
//  IDLE: in_ready=1. On in_valid&in_ready: latch a and ~b, set carry=1, count=0, go to CALC.
//  CALC: in_ready=0. Each cycle, slice k=count does {c,s} = a[k] + nb[k] + carry.
//        s is written to q[k*DIGIT +: DIGIT], then carry<=c and count++.
//        At count==NDIG-1, go to DONE.
//  DONE: out_valid=1, q stable. On out_ready go to IDLE; out_valid drops the next cycle.
//  Latency: acceptance at edge T gives out_valid=1 after edge T+NDIG (4 cycles at defaults).
//  Throughput: one result per NDIG+2 cycles at best. No bypass from DONE to IDLE.
//  in_valid while busy (CALC/DONE) is ignored; the operands are not captured.
//  Operands are sampled only at acceptance; later changes on a/b have no effect.
//  q is undefined-free: partial slices are visible in CALC but are only valid when out_valid=1.
//  Wrap-around: result is mod 2^WIDTH. Final carry=0 means a<b.
//  out_ready while out_valid=0 has no effect.
//  rst_n low at any time (including mid-CALC or in DONE) aborts immediately to the reset values.
//  The in-flight operation is lost and no partial result is presented.
// CONFIGURATION
//  BKA_SUB_BORROW_EN defined: borrow port exists.
//    borrow = ~final carry, registered on the CALC->DONE edge and valid with out_valid.
//  BKA_SUB_BORROW_EN undefined: no borrow port and no extra flop. q behaviour is identical.
// STRUCTURE
//  Package bka_pkg holds:
//    - the state typedef (IDLE/CALC/DONE)
//    - the default WIDTH/DIGIT constants
//    - the NDIG and count-width localparams
//  One sub-module, bka_4_cin: a DIGIT-bit Brent-Kung slice with carry-in and carry-out.
//    Built from the existing pg_onebit/pg_blackcell/pg_graycell/adder cells.
//    Instantiated once; time-multiplexed over the slices.
// TESTING
//  1. a=0x1234, b=0x0234 -> after 4 CALC cycles out_valid=1, q=0x1000, borrow=0.
//  2. a=0x0000, b=0x0001 -> q=0xFFFF, borrow=1; a=0xFFFF, b=0xFFFF -> q=0x0000, borrow=0.
//  3. Hold out_ready=0 for 3 cycles in DONE -> q and out_valid stable, in_ready=0;
//     release -> IDLE next cycle.
//  4. Pulse in_valid with a=0x5555, b=0x1111 during CALC of 0x8000-0x0001 ->
//     q=0x7FFF, second request ignored.
//  5. Deassert rst_n in the 2nd CALC cycle -> out_valid=0, q=0, in_ready=1 at once;
//     the next operation is correct.
//  6. 1000 random back-to-back pairs with random out_ready -> every q equals (a-b)&0xFFFF,
//     none dropped or duplicated.

Source files
------------

// File: rtl/bka_pkg.sv
// -----------------------------------------------------------------------------
// bka_pkg
//   Shared definitions for the digit-serial Brent-Kung subtractor:
//   - state_t      : controller states (IDLE / CALC / DONE)
//   - WIDTH_DEF    : default operand/result width
//   - DIGIT_DEF    : default bits processed per cycle
//   - NDIG_DEF     : default number of compute cycles (WIDTH_DEF / DIGIT_DEF)
//   - CNT_W_DEF    : default width of the digit counter
//   - cnt_width()  : counter width for an arbitrary digit count
// -----------------------------------------------------------------------------
package bka_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int DIGIT_DEF = 4;
  localparam int NDIG_DEF  = WIDTH_DEF / DIGIT_DEF;
  localparam int CNT_W_DEF = (NDIG_DEF > 1) ? $clog2(NDIG_DEF) : 1;

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/bka_4_cin.sv
// -----------------------------------------------------------------------------
// bka_4_cin
//   4-bit Brent-Kung adder slice with carry-in and carry-out.
//   Ports:
//     a, b  in  4  addends
//     cin   in  1  carry into bit 0
//     s     out 4  sum
//     cout  out 1  carry out of bit 3
//   Structure: per-bit propagate/generate, a gray cell folding cin into bit 0,
//   the up-sweep (bits 1:0, 3:2, 3:0) and one down-sweep cell for bit 2:0.
// -----------------------------------------------------------------------------
module bka_4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  logic       g_0c;   // group generate bits 0..-1 (cin treated as bit -1)
  logic       g_10;
  logic       g_32;
  logic       p_32;
  logic       g_30;
  logic       g_20;

  genvar gi;

  // Per-bit propagate/generate.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pg
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Gray cells only need the group generate; the black cell on 3:2 also
  // forwards its group propagate to the 3:0 combine.
  assign g_0c = g[0] | (p[0] & cin);
  assign g_10 = g[1] | (p[1] & g_0c);
  assign g_32 = g[3] | (p[3] & g[2]);
  assign p_32 = p[3] & p[2];
  assign g_30 = g_32 | (p_32 & g_10);
  assign g_20 = g[2] | (p[2] & g_10);

  assign c    = {g_20, g_10, g_0c, cin};
  assign cout = g_30;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_sum
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

endmodule

// File: rtl/bka_sub_16_seq.sv
// -----------------------------------------------------------------------------
// bka_sub_16_seq
//   Digit-serial subtractor q = a - b (mod 2^WIDTH), computed as a + ~b + 1,
//   one DIGIT-bit slice per cycle through a single Brent-Kung slice with a
//   registered carry between slices.
//   Ports:
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      a/b valid
//     in_ready   out  1      operands accepted (IDLE only)
//     a, b       in   WIDTH  minuend, subtrahend (sampled at acceptance only)
//     out_valid  out  1      q valid, held until out_ready
//     out_ready  in   1      consumer takes q
//     q          out  WIDTH  difference
//     borrow     out  1      only with BKA_SUB_BORROW_EN: 1 when a < b
//   Optional feature macro: BKA_SUB_BORROW_EN adds the borrow port and flop.
//   Acceptance at edge T raises out_valid after edge T+NDIG.
// -----------------------------------------------------------------------------
module bka_sub_16_seq
  import bka_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q
`ifdef BKA_SUB_BORROW_EN
  ,
  output logic             borrow
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] nb_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] count_reg;

  logic             accept;
  logic             last;
  logic [DIGIT-1:0] a_dig [NDIG];
  logic [DIGIT-1:0] nb_dig [NDIG];
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT-1:0] slice_s;
  logic             slice_c;

  genvar gi;

  assign accept = (state_reg == IDLE) && in_valid;
  assign last   = (count_reg == CNT_W'(NDIG - 1));

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- operand / carry / count ----------------
  // b is inverted at capture and the carry preset to 1 so the slice only
  // ever adds; that is the two's-complement subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      nb_reg    <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
    end else if (accept) begin
      a_reg     <= a;
      nb_reg    <= ~b;
      carry_reg <= 1'b1;
      count_reg <= '0;
    end else if (state_reg == CALC) begin
      carry_reg <= slice_c;
      count_reg <= last ? '0 : count_reg + 1'b1;
    end
  end

  // ---------------- slice select ----------------
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign a_dig[gi]  = a_reg[gi*DIGIT +: DIGIT];
      assign nb_dig[gi] = nb_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  assign slice_a = a_dig[count_reg];
  assign slice_b = nb_dig[count_reg];

  generate
    if (DIGIT == 4) begin : g_bk
      bka_4_cin u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_c)
      );
    end else begin : g_plain
      // Non-default digit sizes fall back to a behavioural adder.
      assign {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b}
                                + {{DIGIT{1'b0}}, carry_reg};
    end
  endgenerate

  // ---------------- result digits ----------------
  // Each digit owns its register so only the addressed one toggles per cycle.
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_q
      logic [DIGIT-1:0] q_dig_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_dig_reg <= '0;
        end else if ((state_reg == CALC) && (count_reg == CNT_W'(gi))) begin
          q_dig_reg <= slice_s;
        end
      end
      assign q[gi*DIGIT +: DIGIT] = q_dig_reg;
    end
  endgenerate

`ifdef BKA_SUB_BORROW_EN
  // Final carry 0 means a < b; captured as the last slice completes.
  logic borrow_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_reg <= 1'b0;
    end else if ((state_reg == CALC) && last) begin
      borrow_reg <= ~slice_c;
    end
  end
  assign borrow = borrow_reg;
`endif

endmodule

// File: tb/tb_bka_sub_16_seq.sv
// -----------------------------------------------------------------------------
// tb_bka_sub_16_seq
//   Self-checking bench for bka_sub_16_seq: vector table, hand-written
//   latency / hold / busy / reset sequences and a random back-to-back run,
//   with a scoreboard queue filled on acceptance and drained on output.
// -----------------------------------------------------------------------------
module tb_bka_sub_16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
`ifdef BKA_SUB_BORROW_EN
  logic        borrow;
`endif

  bka_sub_16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
`ifdef BKA_SUB_BORROW_EN
    ,
    .borrow    (borrow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        bw;
  } vec_t;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  vec_t sb[$];
  vec_t e_new;
  vec_t e_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: at the falling edge the handshake that the next rising edge
  // will complete is already visible and stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        e_new.a  = a;
        e_new.b  = b;
        e_new.q  = a - b;
        e_new.bw = (a < b);
        sb.push_back(e_new);
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL sb_extra: got q=%h expected no output", q);
        end else begin
          e_pop = sb.pop_front();
          chk("sb_q", {16'h0, q}, {16'h0, e_pop.q});
`ifdef BKA_SUB_BORROW_EN
          chk("sb_borrow", {31'h0, borrow}, {31'h0, e_pop.bw});
`endif
          out_cnt++;
          $display("txn %0d a=%h b=%h q=%h", out_cnt, e_pop.a, e_pop.b, q);
        end
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ok = out_valid;
    if (!ok) begin
      total_cnt++;
      $display("FAIL done_timeout: got out_valid=0 expected 1");
    end
  endtask

  localparam int NV = 7;
  vec_t vec [NV];

  initial begin
    bit ok;
    int cyc;
    int issued;
    int base_acc;
    int base_out;
    int stray;

    vec[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0};
    vec[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1};
    vec[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0};
    vec[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0};
    vec[4] = '{16'h0001, 16'h8000, 16'h8001, 1'b1};
    vec[5] = '{16'hABCD, 16'h1234, 16'h9999, 1'b0};
    vec[6] = '{16'h1111, 16'h5555, 16'hBBBC, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_q", {16'h0, q}, 32'h0);
`ifdef BKA_SUB_BORROW_EN
    chk("rst_borrow", {31'h0, borrow}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency, operand sampling at acceptance, and hold in DONE.
    send(16'h1234, 16'h0234);
    a = 16'hFFFF; b = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("lat_out_valid_low", {31'h0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk("lat_out_valid_high", {31'h0, out_valid}, 32'd1);
    chk("t1_q", {16'h0, q}, 32'h1000);
`ifdef BKA_SUB_BORROW_EN
    chk("t1_borrow", {31'h0, borrow}, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {31'h0, out_valid}, 32'd1);
      chk("hold_q", {16'h0, q}, 32'h1000);
      chk("hold_in_ready", {31'h0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rel_in_ready", {31'h0, in_ready}, 32'd1);

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      send(vec[i].a, vec[i].b);
      wait_done(ok);
      if (ok) begin
        chk("tbl_q", {16'h0, q}, {16'h0, vec[i].q});
`ifdef BKA_SUB_BORROW_EN
        chk("tbl_borrow", {31'h0, borrow}, {31'h0, vec[i].bw});
`endif
      end
      $display("vec %0d a=%h b=%h q=%h", i, vec[i].a, vec[i].b, q);
      @(posedge clk); #1;
    end

    // Request while busy is ignored.
    send(16'h8000, 16'h0001);
    a = 16'h5555; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(ok);
    if (ok) chk("busy_q", {16'h0, q}, 32'h7FFF);
    @(posedge clk); #1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) stray++;
      @(posedge clk); #1;
    end
    chk("busy_no_second", stray, 32'd0);

    // Asynchronous reset in the second CALC cycle.
    send(16'h4321, 16'h1234);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'h0, out_valid}, 32'd0);
    chk("abort_q", {16'h0, q}, 32'h0);
    chk("abort_in_ready", {31'h0, in_ready}, 32'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0F0F, 16'h00FF);
    wait_done(ok);
    if (ok) chk("post_rst_q", {16'h0, q}, 32'h0E10);
    @(posedge clk); #1;

    // Random back-to-back traffic with random consumer stalls.
    base_acc = acc_cnt;
    base_out = out_cnt;
    a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
    issued = 1;
    cyc = 0;
    while ((out_cnt - base_out) < 1000 && cyc < 30000) begin
      @(posedge clk); #1; cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if ((acc_cnt - base_acc) == issued) begin
        if (issued < 1000) begin
          a = 16'($urandom); b = 16'($urandom); issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rand_out_count", out_cnt - base_out, 32'd1000);
    chk("rand_acc_count", acc_cnt - base_acc, 32'd1000);
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
